// File: rtl/program_counter_pkg.sv
// Shared definitions for the SAP-2 program counter, MAR and controller:
// command-select encoding and default address-path constants.
package program_counter_pkg;

   localparam int          PC_WIDTH      = 16;
   localparam logic [15:0] PC_RESET_ADDR = 16'h0000;

   typedef enum logic [2:0] {
      CMD_NONE = 3'd0,
      CMD_INC  = 3'd1,
      CMD_LOAD = 3'd2,
      CMD_CALL = 3'd3,
      CMD_RET  = 3'd4
   } cmd_e;

endpackage

// File: rtl/program_counter_return_stack.sv
// LIFO of return addresses with occupancy pointer; pushes into a full stack
// and pops from an empty stack are ignored here and flagged by the caller.
module return_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = $clog2(DEPTH + 1);

   logic [PW-1:0]    sp_q, sp_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_idx, rd_idx;

   assign wr_idx  = sp_q[AW-1:0];
   assign rd_idx  = wr_idx - AW'(1);
   assign empty_o = (sp_q == '0);
   assign full_o  = (sp_q == PW'(DEPTH));
   assign dout_o  = mem_q[rd_idx];

   always_comb begin
      sp_d = sp_q;
      if (push_i && !full_o) begin
         sp_d = sp_q + PW'(1);
      end else if (pop_i && !empty_o) begin
         sp_d = sp_q - PW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Entry contents are don't-care after reset, so storage carries no reset.
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) begin
         mem_q[wr_idx] <= din_i;
      end
   end

endmodule

// File: rtl/program_counter.sv
// SAP-2 program counter with optional hardware return stack.
// Define PC_RET_STACK_EN to build the stack and CALL/RET semantics.
module program_counter
   import program_counter_pkg::*;
#(
   parameter int               WIDTH      = PC_WIDTH,
   parameter int               DEPTH      = 4,
   parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR)
) (
   input  logic             iClk,
   input  logic             iReset_n,
   input  logic             iInc,
   input  logic             iLoad,
   input  logic             iCall,
   input  logic             iRet,
   input  logic [WIDTH-1:0] iData,
   output logic [WIDTH-1:0] oData,
   output logic             oStackEmpty,
   output logic             oStackFull,
   output logic             oStackErr
);

`ifdef PC_RET_STACK_EN
   localparam bit STACK_EN = 1'b1;
`else
   localparam bit STACK_EN = 1'b0;
`endif

   cmd_e             cmd;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] stk_top;
   logic             stk_empty, stk_full;

   // Without a stack, iRet drops out of the priority chain entirely.
   always_comb begin
      cmd = CMD_NONE;
      if (iRet && STACK_EN) begin
         cmd = CMD_RET;
      end else if (iCall) begin
         cmd = CMD_CALL;
      end else if (iLoad) begin
         cmd = CMD_LOAD;
      end else if (iInc) begin
         cmd = CMD_INC;
      end
   end

   always_comb begin
      pc_d = pc_q;
      case (cmd)
         CMD_INC:  pc_d = pc_q + WIDTH'(1);
         CMD_LOAD: pc_d = iData;
         CMD_CALL: pc_d = iData;
         CMD_RET:  pc_d = stk_empty ? pc_q : stk_top;
         default:  pc_d = pc_q;
      endcase
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         pc_q <= RESET_ADDR;
      end else begin
         pc_q <= pc_d;
      end
   end

`ifdef PC_RET_STACK_EN
   logic err_q, err_d;

   return_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk_i   (iClk),
      .rst_ni  (iReset_n),
      .push_i  (cmd == CMD_CALL),
      .pop_i   (cmd == CMD_RET),
      .din_i   (pc_q),
      .dout_o  (stk_top),
      .empty_o (stk_empty),
      .full_o  (stk_full)
   );

   // Sticky: overflow and underflow are only cleared by reset.
   always_comb begin
      err_d = err_q | ((cmd == CMD_CALL) && stk_full) | ((cmd == CMD_RET) && stk_empty);
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign oStackErr = err_q;
`else
   assign stk_top   = '0;
   assign stk_empty = 1'b1;
   assign stk_full  = 1'b0;
   assign oStackErr = 1'b0;
`endif

   assign oData       = pc_q;
   assign oStackEmpty = stk_empty;
   assign oStackFull  = stk_full;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed scenarios plus random strobes checked
// against a queue-based model of the PC and return stack.
module tb_program_counter;

`ifdef PC_RET_STACK_EN
   localparam bit STACK_EN = 1'b1;
`else
   localparam bit STACK_EN = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic        iClk = 1'b0;
   logic        iReset_n;
   logic        iInc, iLoad, iCall, iRet;
   logic [15:0] iData;
   logic [15:0] oData;
   logic        oStackEmpty, oStackFull, oStackErr;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] m_pc;
   logic [15:0] m_stk[$];
   logic        m_err;

   program_counter #(
      .WIDTH      (16),
      .DEPTH      (DEPTH),
      .RESET_ADDR (16'h0000)
   ) dut (
      .iClk        (iClk),
      .iReset_n    (iReset_n),
      .iInc        (iInc),
      .iLoad       (iLoad),
      .iCall       (iCall),
      .iRet        (iRet),
      .iData       (iData),
      .oData       (oData),
      .oStackEmpty (oStackEmpty),
      .oStackFull  (oStackFull),
      .oStackErr   (oStackErr)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic exp_empty, exp_full;
      exp_empty = STACK_EN ? (m_stk.size() == 0) : 1'b1;
      exp_full  = STACK_EN ? (m_stk.size() == DEPTH) : 1'b0;
      check({tag, ".pc"},    oData,              m_pc);
      check({tag, ".empty"}, {15'd0, oStackEmpty}, {15'd0, exp_empty});
      check({tag, ".full"},  {15'd0, oStackFull},  {15'd0, exp_full});
      check({tag, ".err"},   {15'd0, oStackErr},   {15'd0, m_err});
   endtask

   task automatic model_reset();
      m_pc  = 16'h0000;
      m_stk.delete();
      m_err = 1'b0;
   endtask

   // Reference semantics of one clock edge.
   task automatic model_step(input logic inc, input logic ld, input logic call,
                             input logic ret, input logic [15:0] d);
      if (STACK_EN && ret) begin
         if (m_stk.size() == 0) m_err = 1'b1;
         else                   m_pc  = m_stk.pop_back();
      end else if (call) begin
         if (STACK_EN) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_pc);
            else                      m_err = 1'b1;
         end
         m_pc = d;
      end else if (ld) begin
         m_pc = d;
      end else if (inc) begin
         m_pc = m_pc + 16'd1;
      end
   endtask

   task automatic step(input string tag, input logic inc, input logic ld, input logic call,
                       input logic ret, input logic [15:0] d);
      @(negedge iClk);
      iInc = inc; iLoad = ld; iCall = call; iRet = ret; iData = d;
      @(posedge iClk);
      model_step(inc, ld, call, ret, d);
      #1;
      check_model(tag);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must change without a clock edge.
   task automatic do_reset(input string tag);
      @(negedge iClk);
      #2;
      iReset_n = 1'b0;
      #1;
      model_reset();
      check_model(tag);
      @(negedge iClk);
      iInc = 1'b0; iLoad = 1'b0; iCall = 1'b0; iRet = 1'b0; iData = 16'h0000;
      iReset_n = 1'b1;
   endtask

   initial begin
      iReset_n = 1'b0;
      iInc = 1'b0; iLoad = 1'b0; iCall = 1'b0; iRet = 1'b0; iData = 16'h0000;
      model_reset();
      repeat (2) @(posedge iClk);
      #1;
      check_model("reset");
      check("reset.const_pc", oData, 16'h0000);
      @(negedge iClk);
      iReset_n = 1'b1;

      step("inc1", 1, 0, 0, 0, 16'h0000);
      step("inc2", 1, 0, 0, 0, 16'h0000);
      step("inc3", 1, 0, 0, 0, 16'h0000);
      check("inc3.const", oData, 16'h0003);

      step("ld_fffe", 0, 1, 0, 0, 16'hFFFE);
      step("inc_ffff", 1, 0, 0, 0, 16'h0000);
      step("inc_wrap", 1, 0, 0, 0, 16'h0000);
      check("wrap.const", oData, 16'h0000);

      step("ld_0010", 0, 1, 0, 0, 16'h0010);
      step("call_0200", 0, 0, 1, 0, 16'h0200);
      step("call_0300", 0, 0, 1, 0, 16'h0300);
      step("ret_a", 0, 0, 0, 1, 16'h0000);
      step("ret_b", 0, 0, 0, 1, 16'h0000);

      do_reset("rst_ovf");
      step("ld_0001", 0, 1, 0, 0, 16'h0001);
      for (int i = 0; i <= DEPTH; i++) step($sformatf("ovf_call%0d", i), 0, 0, 1, 0, 16'h0100);
      for (int i = 0; i < DEPTH; i++) step($sformatf("ovf_ret%0d", i), 0, 0, 0, 1, 16'h0000);

      do_reset("rst_unf");
      step("ld_0042", 0, 1, 0, 0, 16'h0042);
      step("ret_empty", 0, 0, 0, 1, 16'h0000);
      step("hold", 0, 0, 0, 0, 16'h1234);
      step("inc_keep", 1, 0, 0, 0, 16'h0000);
      do_reset("rst_clr");

      step("ld_0123", 0, 1, 0, 0, 16'h0123);
      step("call_0777", 0, 0, 1, 0, 16'h0777);
      step("all4", 1, 1, 1, 1, 16'h0999);
      step("ld_inc", 1, 1, 0, 0, 16'h0500);
      check("ld_inc.const", oData, 16'h0500);

      for (int i = 0; i < 400; i++) begin
         logic [3:0]  r;
         logic [15:0] d;
         r = 4'($urandom);
         d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
         if ($urandom_range(0, 63) == 0) do_reset($sformatf("rnd_rst%0d", i));
         else step($sformatf("rnd%0d", i), r[0], r[1], r[2], r[3], d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
